// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: FSM states and
// operand-forwarding select codes.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    D_WAIT = 2'd1,
    I_WAIT = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// Operand forwarding select for one Execute source operand.
// The Memory stage is the younger producer, so it wins over Writeback.
module forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rsE,
  input  logic             regWriteM,
  input  logic [REG_W-1:0] rdM,
  input  logic             regWriteW,
  input  logic [REG_W-1:0] rdW,
  output logic [1:0]       fwd
);

  logic hit_m;
  logic hit_w;

  assign hit_m = regWriteM && (rdM != '0)
              && (rdM == rsE);
  assign hit_w = regWriteW && (rdW != '0)
              && (rdW == rsE);

  always_comb begin
    fwd = FWD_RF;
    priority case (1'b1)
      hit_m:   fwd = FWD_MEM;
      hit_w:   fwd = FWD_WB;
      default: fwd = FWD_RF;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall,
// branch flush, I/D cache-miss wait FSM and a stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1D,
  input  logic [REG_W-1:0] rs2D,
  input  logic [REG_W-1:0] rs1E,
  input  logic [REG_W-1:0] rs2E,
  input  logic [REG_W-1:0] rdE,
  input  logic             loadE,
  input  logic             pcSrcE,
  input  logic             regWriteM,
  input  logic [REG_W-1:0] rdM,
  input  logic             regWriteW,
  input  logic [REG_W-1:0] rdW,
  input  logic             dmiss,
  input  logic             drdy,
  input  logic             imiss,
  input  logic             irdy,
  input  logic             cnt_clr,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             stallW,
  output logic             flushD,
  output logic             flushE,
  output logic [1:0]       fwdAE,
  output logic [1:0]       fwdBE,
  output logic [CNT_W-1:0] stall_cnt
);

  hz_state_t state;
  hz_state_t state_n;
  logic      redir_pend;
  logic      redir_n;
  logic      load_use;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  forward_unit #(.REG_W(REG_W)) u_fwd_a (
    .rsE       (rs1E),
    .regWriteM (regWriteM),
    .rdM       (rdM),
    .regWriteW (regWriteW),
    .rdW       (rdW),
    .fwd       (fwd_a)
  );

  forward_unit #(.REG_W(REG_W)) u_fwd_b (
    .rsE       (rs2E),
    .regWriteM (regWriteM),
    .rdM       (rdM),
    .regWriteW (regWriteW),
    .rdW       (rdW),
    .fwd       (fwd_b)
  );

  assign fwdAE = rst ? FWD_RF : fwd_a;
  assign fwdBE = rst ? FWD_RF : fwd_b;

  assign load_use = loadE && (rdE != '0)
                 && ((rdE == rs1D) || (rdE == rs2D));

  always_comb begin
    stallF  = 1'b0;
    stallD  = 1'b0;
    stallE  = 1'b0;
    stallM  = 1'b0;
    stallW  = 1'b0;
    flushD  = 1'b0;
    flushE  = 1'b0;
    state_n = state;
    redir_n = redir_pend;
    if (rst) begin
      flushD  = 1'b1;
      flushE  = 1'b1;
      state_n = RUN;
      redir_n = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          priority case (1'b1)
            dmiss: begin
              stallF  = 1'b1;
              stallD  = 1'b1;
              stallE  = 1'b1;
              stallM  = 1'b1;
              stallW  = 1'b1;
              state_n = D_WAIT;
            end
            imiss: begin
              stallF  = 1'b1;
              flushD  = 1'b1;
              flushE  = pcSrcE;
              state_n = I_WAIT;
              redir_n = pcSrcE;
            end
            pcSrcE: begin
              flushD = 1'b1;
              flushE = 1'b1;
            end
            load_use: begin
              stallF = 1'b1;
              stallD = 1'b1;
              flushE = 1'b1;
            end
            default: ;
          endcase
        end
        D_WAIT: begin
          stallF = 1'b1;
          stallD = 1'b1;
          stallE = 1'b1;
          stallM = 1'b1;
          stallW = 1'b1;
          if (drdy) begin
            state_n = imiss ? I_WAIT : RUN;
          end
        end
        I_WAIT: begin
          priority case (1'b1)
            dmiss: begin
              stallF  = 1'b1;
              stallD  = 1'b1;
              stallE  = 1'b1;
              stallM  = 1'b1;
              stallW  = 1'b1;
              state_n = D_WAIT;
            end
            irdy: begin
              // A redirect seen during the wait kills the stale fetch
              flushD  = redir_pend || pcSrcE;
              flushE  = pcSrcE;
              state_n = RUN;
            end
            default: begin
              stallF = 1'b1;
              flushD = 1'b1;
              flushE = pcSrcE;
              if (pcSrcE) begin
                redir_n = 1'b1;
              end
            end
          endcase
        end
        default: state_n = RUN;
      endcase
      if (state_n == RUN) begin
        redir_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    state      <= state_n;
    redir_pend <= redir_n;
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt <= '0;
    end else if (stallF && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: behavioural model compared
// every cycle, plus directed literal checks and random stimulus.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int RW = 5;
  localparam int CW = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [RW-1:0] rs1D = '0, rs2D = '0;
  logic [RW-1:0] rs1E = '0, rs2E = '0, rdE = '0;
  logic [RW-1:0] rdM = '0, rdW = '0;
  logic loadE = 0, pcSrcE = 0;
  logic regWriteM = 0, regWriteW = 0;
  logic dmiss = 0, drdy = 0, imiss = 0, irdy = 0;
  logic cnt_clr = 0;
  logic stallF, stallD, stallE, stallM, stallW;
  logic flushD, flushE;
  logic [1:0] fwdAE, fwdBE;
  logic [CW-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  bit m_dw = 0;
  bit m_iw = 0;
  bit m_pend = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .loadE(loadE), .pcSrcE(pcSrcE),
    .regWriteM(regWriteM), .rdM(rdM),
    .regWriteW(regWriteW), .rdW(rdW),
    .dmiss(dmiss), .drdy(drdy),
    .imiss(imiss), .irdy(irdy),
    .cnt_clr(cnt_clr),
    .stallF(stallF), .stallD(stallD),
    .stallE(stallE), .stallM(stallM),
    .stallW(stallW),
    .flushD(flushD), .flushE(flushE),
    .fwdAE(fwdAE), .fwdBE(fwdBE),
    .stall_cnt(stall_cnt)
  );

  function automatic logic [1:0] mfwd(
    logic [RW-1:0] rs);
    if (regWriteM && rdM != 0 && rdM == rs)
      return 2'b10;
    if (regWriteW && rdW != 0 && rdW == rs)
      return 2'b01;
    return 2'b00;
  endfunction

  // {sF,sD,sE,sM,sW,fD,fE,fA,fB}
  function automatic logic [10:0] mexp();
    logic sf, sd, sdn, fd, fe;
    logic lu;
    sf = 0; sd = 0; sdn = 0; fd = 0; fe = 0;
    lu = loadE && rdE != 0
      && (rdE == rs1D || rdE == rs2D);
    if (rst)
      return {5'b0, 2'b11, 4'b0};
    if (m_dw || dmiss) begin
      sf = 1; sd = 1; sdn = 1;
    end else if (m_iw) begin
      fe = pcSrcE;
      if (irdy) fd = m_pend || pcSrcE;
      else begin sf = 1; fd = 1; end
    end else if (imiss) begin
      sf = 1; fd = 1; fe = pcSrcE;
    end else if (pcSrcE) begin
      fd = 1; fe = 1;
    end else if (lu) begin
      sf = 1; sd = 1; fe = 1;
    end
    return {sf, sd, sdn, sdn, sdn, fd, fe,
            mfwd(rs1E), mfwd(rs2E)};
  endfunction

  always @(posedge clk) begin
    logic [10:0] e;
    e = mexp();
    if (rst) begin
      m_dw = 0; m_iw = 0; m_pend = 0; m_cnt = 0;
    end else begin
      if (cnt_clr) m_cnt = 0;
      else if (e[10] && m_cnt < CMAX) m_cnt++;
      if (m_dw) begin
        if (drdy) begin m_dw = 0; m_iw = imiss; end
      end else if (dmiss) begin
        m_dw = 1; m_iw = 0;
      end else if (m_iw) begin
        if (irdy) m_iw = 0;
        else if (pcSrcE) m_pend = 1;
      end else if (imiss) begin
        m_iw = 1; m_pend = pcSrcE;
      end
      if (!m_dw && !m_iw) m_pend = 0;
    end
  end

  always @(negedge clk) begin
    logic [10:0] e, g;
    if (chk_en) begin
      e = mexp();
      g = {stallF, stallD, stallE, stallM, stallW,
           flushD, flushE, fwdAE, fwdBE};
      n_cmp++;
      if (g !== e || stall_cnt !== CW'(m_cnt)) begin
        n_bad++;
        $display("FAIL model t=%0t got=%b/%0d exp=%b/%0d",
                 $time, g, stall_cnt, e, m_cnt);
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; loadE = 0; pcSrcE = 0;
    regWriteM = 0; regWriteW = 0;
    dmiss = 0; drdy = 0; imiss = 0; irdy = 0;
    cnt_clr = 0;
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0;
    rdE = 0; rdM = 0; rdW = 0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk_en = 1;
    // reset with a forwarding match present
    regWriteM = 1; rdM = 5; rs1E = 5;
    @(negedge clk);
    chk("rst_flushD", flushD, 1);
    chk("rst_flushE", flushE, 1);
    chk("rst_stallF", stallF, 0);
    chk("rst_fwdAE", fwdAE, 0);
    nxt();
    idle();
    @(negedge clk);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_state", int'(dut.state), int'(RUN));

    // forwarding priority
    regWriteM = 1; rdM = 5; regWriteW = 1; rdW = 5;
    rs1E = 5; rs2E = 5;
    @(negedge clk);
    chk("fwd_mem", fwdAE, 2);
    chk("fwdB_mem", fwdBE, 2);
    nxt();
    rdM = 0;
    @(negedge clk);
    chk("fwd_wb", fwdAE, 1);
    nxt();
    idle();

    // load-use then branch override
    loadE = 1; rdE = 3; rs2D = 3;
    @(negedge clk);
    chk("lu_stallF", stallF, 1);
    chk("lu_stallD", stallD, 1);
    chk("lu_flushE", flushE, 1);
    nxt();
    loadE = 0;
    @(negedge clk);
    chk("lu_once", stallF, 0);
    nxt();
    loadE = 1; pcSrcE = 1;
    @(negedge clk);
    chk("br_flushD", flushD, 1);
    chk("br_flushE", flushE, 1);
    chk("br_stallF", stallF, 0);
    nxt();
    idle();

    // data miss, 4 cycles, drdy on 4th
    cnt_clr = 1;
    nxt();
    cnt_clr = 0;
    for (int i = 1; i <= 4; i++) begin
      dmiss = 1; drdy = (i == 4);
      @(negedge clk);
      chk("dm_stallF", stallF, 1);
      chk("dm_stallW", stallW, 1);
      nxt();
    end
    idle();
    @(negedge clk);
    chk("dm_run", int'(dut.state), int'(RUN));
    chk("dm_cnt", stall_cnt, 4);
    chk("dm_free", stallF, 0);
    nxt();

    // inst miss with redirect during the wait
    imiss = 1;
    @(negedge clk);
    chk("im1_flushD", flushD, 1);
    nxt();
    pcSrcE = 1;
    @(negedge clk);
    chk("im2_flushD", flushD, 1);
    nxt();
    pcSrcE = 0; irdy = 1;
    @(negedge clk);
    chk("im_pend", dut.redir_pend, 1);
    chk("im_exit_flushD", flushD, 1);
    chk("im_exit_stallF", stallF, 0);
    nxt();
    idle();
    @(negedge clk);
    chk("im_pend_clr", dut.redir_pend, 0);
    chk("im_run", int'(dut.state), int'(RUN));
    nxt();

    // inst miss without redirect: no flush on irdy
    imiss = 1;
    nxt();
    irdy = 1;
    @(negedge clk);
    chk("im_noredir_flushD", flushD, 0);
    nxt();
    idle();

    // dmiss inside I_WAIT keeps redirect, returns to I_WAIT
    imiss = 1;
    nxt();
    pcSrcE = 1;
    nxt();
    pcSrcE = 0; dmiss = 1;
    @(negedge clk);
    chk("id_freeze", stallE, 1);
    nxt();
    drdy = 1;
    @(negedge clk);
    chk("id_pend", dut.redir_pend, 1);
    nxt();
    dmiss = 0; drdy = 0; irdy = 1;
    @(negedge clk);
    chk("id_iwait", int'(dut.state), int'(I_WAIT));
    chk("id_flushD", flushD, 1);
    nxt();
    idle();

    // reset while in D_WAIT
    dmiss = 1;
    nxt();
    rst = 1;
    @(negedge clk);
    chk("rd_flushD", flushD, 1);
    chk("rd_flushE", flushE, 1);
    chk("rd_stallF", stallF, 0);
    nxt();
    idle();
    @(negedge clk);
    chk("rd_run", int'(dut.state), int'(RUN));
    chk("rd_cnt", stall_cnt, 0);
    nxt();

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(63) == 0);
      loadE = $urandom_range(1);
      pcSrcE = ($urandom_range(3) == 0);
      regWriteM = $urandom_range(1);
      regWriteW = $urandom_range(1);
      dmiss = ($urandom_range(7) == 0);
      drdy = ($urandom_range(2) == 0);
      imiss = ($urandom_range(3) == 0);
      irdy = ($urandom_range(2) == 0);
      cnt_clr = ($urandom_range(31) == 0);
      rs1D = RW'($urandom_range(3));
      rs2D = RW'($urandom_range(3));
      rs1E = RW'($urandom_range(3));
      rs2E = RW'($urandom_range(3));
      rdE = RW'($urandom_range(3));
      rdM = RW'($urandom_range(3));
      rdW = RW'($urandom_range(3));
      nxt();
    end
    idle();

    // counter saturation and clear
    rst = 1;
    nxt();
    rst = 0; dmiss = 1;
    for (int i = 0; i < CMAX + 5; i++) nxt();
    @(negedge clk);
    chk("sat_max", stall_cnt, CMAX);
    nxt();
    @(negedge clk);
    chk("sat_hold", stall_cnt, CMAX);
    cnt_clr = 1;
    nxt();
    cnt_clr = 0;
    @(negedge clk);
    chk("sat_clr", stall_cnt, 0);
    nxt();
    @(negedge clk);
    chk("sat_restart", stall_cnt, 1);
    nxt();
    idle();
    rst = 1;
    nxt();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
